// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: two-requester register-file writeback arbiter, one slot per requester.
// Optional feature macro RF_ARB_ROUND_ROBIN_EN: round-robin tie-break (otherwise A wins ties).
module rf_write_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  reqA,
    input  logic [ADDR_WIDTH-1:0] regA,
    input  logic [DATA_WIDTH-1:0] dataA,
    output logic                  ackA,
    input  logic                  reqB,
    input  logic [ADDR_WIDTH-1:0] regB,
    input  logic [DATA_WIDTH-1:0] dataB,
    output logic                  ackB,
    output logic                  rfWe,
    output logic [ADDR_WIDTH-1:0] rfWriteRegister,
    output logic [DATA_WIDTH-1:0] rfWriteData,
    input  logic [ADDR_WIDTH-1:0] lookupReg,
    output logic                  lookupPending
);
    logic                  valid_a_q, valid_a_d, valid_b_q, valid_b_d;
    logic [ADDR_WIDTH-1:0] reg_a_q, reg_a_d, reg_b_q, reg_b_d;
    logic [DATA_WIDTH-1:0] data_a_q, data_a_d, data_b_q, data_b_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] wr_reg_q, wr_reg_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  xfer_a, xfer_b, grant_a, grant_b;
`ifdef RF_ARB_ROUND_ROBIN_EN
    logic                  last_b_q, last_b_d;
`endif

    assign ackA            = ~valid_a_q;
    assign ackB            = ~valid_b_q;
    assign xfer_a          = reqA & ~valid_a_q;
    assign xfer_b          = reqB & ~valid_b_q;
    assign rfWe            = we_q;
    assign rfWriteRegister = wr_reg_q;
    assign rfWriteData     = wr_data_q;
    assign lookupPending   = (lookupReg != '0) &&
                             ((valid_a_q && reg_a_q == lookupReg) ||
                              (valid_b_q && reg_b_q == lookupReg) ||
                              (we_q && wr_reg_q == lookupReg));

    // Grant one valid slot per edge; a tie goes to A unless round-robin says B
    always_comb begin
`ifdef RF_ARB_ROUND_ROBIN_EN
        grant_a = valid_a_q & (~valid_b_q | last_b_q);
`else
        grant_a = valid_a_q;
`endif
        grant_b = valid_b_q & ~grant_a;
    end

    // Slot loading/draining and output register next state
    always_comb begin
        valid_a_d = xfer_a ? (regA != '0) : (valid_a_q & ~grant_a);
        reg_a_d   = xfer_a ? regA : reg_a_q;
        data_a_d  = xfer_a ? dataA : data_a_q;
        valid_b_d = xfer_b ? (regB != '0) : (valid_b_q & ~grant_b);
        reg_b_d   = xfer_b ? regB : reg_b_q;
        data_b_d  = xfer_b ? dataB : data_b_q;
        we_d      = grant_a | grant_b;
        wr_reg_d  = grant_a ? reg_a_q : grant_b ? reg_b_q : wr_reg_q;
        wr_data_d = grant_a ? data_a_q : grant_b ? data_b_q : wr_data_q;
`ifdef RF_ARB_ROUND_ROBIN_EN
        last_b_d  = grant_a ? 1'b0 : grant_b ? 1'b1 : last_b_q;
`endif
    end

    // State registers; reset empties both slots and drops any pending write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_a_q <= 1'b0;
            reg_a_q   <= '0;
            data_a_q  <= '0;
            valid_b_q <= 1'b0;
            reg_b_q   <= '0;
            data_b_q  <= '0;
            we_q      <= 1'b0;
            wr_reg_q  <= '0;
            wr_data_q <= '0;
`ifdef RF_ARB_ROUND_ROBIN_EN
            last_b_q  <= 1'b1;
`endif
        end else begin
            valid_a_q <= valid_a_d;
            reg_a_q   <= reg_a_d;
            data_a_q  <= data_a_d;
            valid_b_q <= valid_b_d;
            reg_b_q   <= reg_b_d;
            data_b_q  <= data_b_d;
            we_q      <= we_d;
            wr_reg_q  <= wr_reg_d;
            wr_data_q <= wr_data_d;
`ifdef RF_ARB_ROUND_ROBIN_EN
            last_b_q  <= last_b_d;
`endif
        end
    end
endmodule

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, sets the register data width.
REQ-002 Parameter ADDR_WIDTH, default 5, sets the register index width (32 registers).
REQ-003 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1, asynchronous, active-high reset.
REQ-005 Port reqA, input, 1, writeback request from requester A (ALU pipe).
REQ-006 Port regA, input, ADDR_WIDTH, destination register for A.
REQ-007 Port dataA, input, DATA_WIDTH, write data for A.
REQ-008 Port ackA, output, 1, A's slot is free; a transfer occurs when reqA and ackA are both high at a rising edge.
REQ-009 Ports reqB, regB, dataB and ackB mirror REQ-005 to REQ-008 for requester B (load pipe).
REQ-010 Port rfWe, output, 1, register-file write enable.
REQ-011 Port rfWriteRegister, output, ADDR_WIDTH, register-file write index.
REQ-012 Port rfWriteData, output, DATA_WIDTH, register-file write data.
REQ-013 Port lookupReg, input, ADDR_WIDTH, register index queried for pending writes.
REQ-014 Port lookupPending, output, 1, combinational: lookupReg is nonzero and matches a valid slot or the asserted output register.

Function
REQ-015 The block SHALL hold one slot per requester: a valid flag, an index and data.
REQ-016 The block SHALL drive ackX = ~validX, from state only, with no combinational path from reqX.
REQ-017 A transfer with a nonzero index SHALL load slot X and set validX at that edge.
REQ-018 A transfer with index 0 SHALL be acknowledged and discarded, leaving validX at 0.
REQ-019 At each edge where at least one slot is valid, the block SHALL grant exactly one slot, per REQ-027 and REQ-028.
REQ-020 At a grant, the block SHALL copy the granted slot into rfWriteRegister and rfWriteData, set rfWe to 1, and clear that slot's valid flag.
REQ-021 At an edge with no valid slot, the block SHALL set rfWe to 0; rfWriteRegister and rfWriteData SHALL hold their values.
REQ-022 Latency SHALL be as follows:
- transfer at edge N;
- rfWe high during cycle N+1 to N+2, when the slot is granted at edge N+1;
- register file written at edge N+2.
REQ-023 A slot emptied at edge N SHALL raise ackX during cycle N+1; the sustained rate per requester with no contention SHALL be one transfer every 2 cycles.
REQ-024 When A and B both hold the same index, writes SHALL reach the output in grant order, and the later grant SHALL be the final value.
REQ-025 The block SHALL keep no other state; in particular, it SHALL have no back-pressure from the register file.

Reset
REQ-026 While rst is high, the block SHALL immediately force the following, discarding any in-flight or pending data:
- validA = 0, validB = 0, so ackA = 1 and ackB = 1;
- rfWe = 0;
- rfWriteRegister = 0, rfWriteData = 0;
- lastGrant = B.

Configuration
REQ-027 With macro RF_ARB_ROUND_ROBIN_EN defined, the block SHALL behave as follows:
- when both slots are valid, it SHALL grant the requester not recorded in lastGrant;
- lastGrant SHALL update on every grant;
- after reset, A SHALL win the first tie.
REQ-028 With RF_ARB_ROUND_ROBIN_EN undefined, the block SHALL always grant A on a tie, and lastGrant SHALL not be implemented.

Verification
REQ-029 Reset mid-operation: both slots valid, rst pulsed between edges -> immediately ackA = ackB = 1 and rfWe = 0; no write appears after release.
REQ-030 Single write: reqA with regA = 7 and dataA = 0x1234 at edge N -> rfWe = 1, rfWriteRegister = 7, rfWriteData = 0x1234 during cycle N+1; rfWe = 0 during cycle N+2.
REQ-031 Zero index: reqB with regB = 0 and dataB = 0xFFFF -> ackB stays 1 and rfWe never asserts.
REQ-032 Tie, RF_ARB_ROUND_ROBIN_EN defined: A and B transfer together with regA = 3 = regB, dataA = 1, dataB = 2, then both re-request every cycle -> first grant A, then B, alternating; the final value written to register 3 comes from B.
REQ-033 Tie, macro undefined: same stimulus as REQ-032 -> A always granted first on each tie; B's write follows only once A's slot is empty.
REQ-034 Lookup: slot A valid with index 9, lookupReg = 9 -> lookupPending = 1; lookupReg = 0 -> lookupPending = 0; lookupPending stays 1 while rfWe is high with index 9.
